// File: rtl/pipe_ir_queue.sv
// DEPTH-entry {pc4, instruction} queue between IF and ID with show-ahead head and redirect flush.
// Optional fall-through on an empty queue: define PIPE_IR_QUEUE_BYPASS_EN.
module pipe_ir_queue #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              push,
    input  logic [WIDTH-1:0]  pc4_in,
    input  logic [WIDTH-1:0]  ins_in,
    output logic              full,
    input  logic              pop,
    input  logic              flush,
    output logic              valid,
    output logic [WIDTH-1:0]  dpc4,
    output logic [WIDTH-1:0]  inst,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               stored_valid;
    logic               bypass_take;
    logic               push_ok;
    logic               pop_ok;

    assign stored_valid = (count_q != '0);
    assign full         = (count_q == DepthCnt);
    assign count        = count_q;

`ifdef PIPE_IR_QUEUE_BYPASS_EN
    logic bypass;

    assign bypass      = !stored_valid && push && !flush;
    // Fall-through entry consumed by ID this cycle never touches storage.
    assign bypass_take = bypass && pop;

    always_comb begin
        valid = stored_valid || bypass;
        dpc4  = '0;
        inst  = '0;
        if (stored_valid) begin
            {dpc4, inst} = mem_q[rd_ptr_q];
        end else if (bypass) begin
            dpc4 = pc4_in;
            inst = ins_in;
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        valid = stored_valid;
        dpc4  = '0;
        inst  = '0;
        if (stored_valid) begin
            {dpc4, inst} = mem_q[rd_ptr_q];
        end
    end
`endif

    // Push on full is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop && stored_valid;
    assign push_ok = push && (!full || pop_ok) && !bypass_take;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; outputs are gated by valid instead.
    always_ff @(posedge clk) begin
        if (clrn && !flush && push_ok) begin
            mem_q[wr_ptr_q] <= {pc4_in, ins_in};
        end
    end

endmodule
